alu_pipe: RTL and testbench

- Parametrised, registered successor to the team's combinational ALU; same opcode set and operand semantics.
- Adds a two-stage pipeline, valid/ready handshakes on both sides, status flags and invalid-opcode reporting.
- Sits between the operand/instruction source and the result sink of the datapath.
- Sustains one operation per cycle when the sink is ready.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_pipe_if.sv | 32 +++
 rtl/alu_core.sv | 72 +++++++
 rtl/alu_pipe.sv | 101 ++++++++++
 tb/tb_alu_pipe.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes and flag bundle for the pipelined ALU.
// Optional build macro: ALU_SATURATE_EN (saturating ADD/SUB, used by alu_core).
package alu_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] ADD = 6'b100000;
  localparam logic [OP_W-1:0] SUB = 6'b100010;
  localparam logic [OP_W-1:0] AND = 6'b100100;
  localparam logic [OP_W-1:0] OR  = 6'b100101;
  localparam logic [OP_W-1:0] XOR = 6'b100110;
  localparam logic [OP_W-1:0] SRA = 6'b000011;
  localparam logic [OP_W-1:0] SRL = 6'b000010;
  localparam logic [OP_W-1:0] NOR = 6'b100111;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
    logic op_err;
  } alu_flags_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/opcode input channel and result output channel of alu_pipe.
// slave: the ALU side; master: the source/sink side (testbench or datapath).
interface alu_pipe_if #(
  parameter int unsigned LEN_DATO = 8,
  parameter int unsigned LEN_OP   = 6
);

  logic                i_valid;
  logic                o_ready;
  logic [LEN_DATO-1:0] i_dato_a;
  logic [LEN_DATO-1:0] i_dato_b;
  logic [LEN_OP-1:0]   i_op_code;
  logic                o_valid;
  logic                i_ready;
  logic [LEN_DATO-1:0] o_resultado;
  logic                o_zero;
  logic                o_neg;
  logic                o_carry;
  logic                o_ovf;
  logic                o_op_err;

  modport slave (
    input  i_valid, i_dato_a, i_dato_b, i_op_code, i_ready,
    output o_ready, o_valid, o_resultado, o_zero, o_neg, o_carry, o_ovf, o_op_err
  );

  modport master (
    output i_valid, i_dato_a, i_dato_b, i_op_code, i_ready,
    input  o_ready, o_valid, o_resultado, o_zero, o_neg, o_carry, o_ovf, o_op_err
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: (a, b, op) -> (result, flags).
// Ports: a, b operands; op opcode; result_c result; flags_c status bundle.
// Macro ALU_SATURATE_EN: ADD/SUB clamp to the signed range on overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned LEN_DATO = 8,
  parameter int unsigned LEN_OP   = 6
) (
  input  logic [LEN_DATO-1:0] a,
  input  logic [LEN_DATO-1:0] b,
  input  logic [LEN_OP-1:0]   op,
  output logic [LEN_DATO-1:0] result_c,
  output alu_flags_t          flags_c
);

  localparam int unsigned MSB = LEN_DATO - 1;

  logic [LEN_DATO:0]   sum;
  logic [LEN_DATO:0]   diff;
  logic [LEN_DATO-1:0] b_neg;
  logic [LEN_DATO-1:0] res;
  logic                carry;
  logic                ovf;
  logic                op_err;
  logic                shift_big;

  // Operation select; the extra sum/diff bit gives carry and borrow.
  always_comb begin
    sum       = {1'b0, a} + {1'b0, b};
    diff      = {1'b0, a} - {1'b0, b};
    b_neg     = ~b + LEN_DATO'(1);
    shift_big = (32'(b) >= LEN_DATO);
    res       = a;
    carry     = 1'b0;
    ovf       = 1'b0;
    op_err    = 1'b0;
    case (op)
      LEN_OP'(ADD): begin
        res   = sum[MSB:0];
        carry = sum[LEN_DATO];
        ovf   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      LEN_OP'(SUB): begin
        res   = diff[MSB:0];
        carry = diff[LEN_DATO];
        ovf   = (a[MSB] == b_neg[MSB]) && (diff[MSB] != a[MSB]);
      end
      LEN_OP'(AND): res = a & b;
      LEN_OP'(OR):  res = a | b;
      LEN_OP'(XOR): res = a ^ b;
      LEN_OP'(NOR): res = ~(a | b);
      LEN_OP'(SRA): res = shift_big ? {LEN_DATO{a[MSB]}} : LEN_DATO'($signed(a) >>> b);
      LEN_OP'(SRL): res = shift_big ? '0 : (a >> b);
      default:      op_err = 1'b1;
    endcase
`ifdef ALU_SATURATE_EN
    // Overflow is only ever set by ADD/SUB; direction follows A's sign.
    if (ovf) begin
      res = a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
    end
`endif
  end

  assign result_c       = res;
  assign flags_c.zero   = (res == '0);
  assign flags_c.neg    = res[MSB];
  assign flags_c.carry  = carry;
  assign flags_c.ovf    = ovf;
  assign flags_c.op_err = op_err;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// Ports: i_clock, i_reset (sync, active-high); bus (alu_pipe_if.slave) carries
// operand/opcode beats in and result/flag beats out.
// Macro ALU_SATURATE_EN selects saturating ADD/SUB inside alu_core.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned LEN_DATO = 8,
  parameter int unsigned LEN_OP   = 6
) (
  input  logic      i_clock,
  input  logic      i_reset,
  alu_pipe_if.slave bus
);

  logic                s1_valid_q, s1_valid_d;
  logic [LEN_DATO-1:0] a_q, a_d;
  logic [LEN_DATO-1:0] b_q, b_d;
  logic [LEN_OP-1:0]   op_q, op_d;
  logic                s2_valid_q, s2_valid_d;
  logic [LEN_DATO-1:0] res_q, res_d;
  alu_flags_t          flags_q, flags_d;

  logic                s2_load_c;
  logic                ready_c;
  logic                accept_c;
  logic [LEN_DATO-1:0] core_res_c;
  alu_flags_t          core_flags_c;

  alu_core #(
    .LEN_DATO (LEN_DATO),
    .LEN_OP   (LEN_OP)
  ) u_core (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .result_c (core_res_c),
    .flags_c  (core_flags_c)
  );

  // Stage 2 loads when empty or draining; stage 1 refills whenever it moves on or is empty.
  always_comb begin
    s2_load_c  = !s2_valid_q || bus.i_ready;
    ready_c    = !s1_valid_q || s2_load_c;
    accept_c   = bus.i_valid && ready_c;
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    flags_d    = flags_q;
    if (s2_load_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d   = core_res_c;
        flags_d = core_flags_c;
      end
    end
    if (s2_load_c || !s1_valid_q) begin
      s1_valid_d = accept_c;
      if (accept_c) begin
        a_d  = bus.i_dato_a;
        b_d  = bus.i_dato_b;
        op_d = bus.i_op_code;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
    end
  end

  // Stage-1 operand registers carry no reset; their valid bit guards them.
  always_ff @(posedge i_clock) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
  end

  assign bus.o_ready     = ready_c;
  assign bus.o_valid     = s2_valid_q;
  assign bus.o_resultado = res_q;
  assign bus.o_zero      = flags_q.zero;
  assign bus.o_neg       = flags_q.neg;
  assign bus.o_carry     = flags_q.carry;
  assign bus.o_ovf       = flags_q.ovf;
  assign bus.o_op_err    = flags_q.op_err;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (LEN_DATO=8): directed vectors, handshake
// scenarios, reset flush and a randomized run against an arithmetic model.
module tb_alu_pipe;

  typedef struct {
    logic       valid;
    logic       ready;
    logic [7:0] res;
    logic [4:0] flags;   // {zero, neg, carry, ovf, op_err}
  } obs_t;

  typedef struct {
    logic [7:0] res;
    logic [4:0] flags;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
    logic [4:0] flags;
  } dvec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb [$];

  alu_pipe_if #(.LEN_DATO(8), .LEN_OP(6)) bus ();

  alu_pipe #(.LEN_DATO(8), .LEN_OP(6)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model from the operation rules using integer arithmetic.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    exp_t e;
    int ua = int'(a);
    int ub = int'(b);
    int sa = (ua >= 128) ? ua - 256 : ua;
    int sb_ = (ub >= 128) ? ub - 256 : ub;
    int r = ua;
    int bn;
    logic [7:0] t;
    bit c = 0;
    bit v = 0;
    bit err = 0;
    case (op)
      6'b100000: begin
        r = ua + ub;
        c = (r > 255);
        r = r % 256;
        v = (sa + sb_ > 127) || (sa + sb_ < -128);
      end
      6'b100010: begin
        r = ua - ub;
        c = (r < 0);
        r = (r + 256) % 256;
        bn = (256 - ub) % 256;
        v = ((ua >= 128) == (bn >= 128)) && ((r >= 128) != (ua >= 128));
      end
      6'b100100: begin t = a & b;    r = int'(t); end
      6'b100101: begin t = a | b;    r = int'(t); end
      6'b100110: begin t = a ^ b;    r = int'(t); end
      6'b100111: begin t = ~(a | b); r = int'(t); end
      6'b000011: r = (ub >= 8) ? ((sa < 0) ? 255 : 0) : ((sa >>> ub) & 255);
      6'b000010: r = (ub >= 8) ? 0 : (ua >> ub);
      default:   err = 1;
    endcase
`ifdef ALU_SATURATE_EN
    if (v) r = (ua >= 128) ? 128 : 127;
`endif
    e.res   = 8'(r);
    e.flags = {(r == 0), (r >= 128), c, v, err};
    e.cyc   = 0;
    return e;
  endfunction

  // One clock cycle: drive at the falling edge, sample 1 ns later.
  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [5:0] op, input logic rdy, output obs_t o);
    @(negedge clk);
    bus.i_valid   = v;
    bus.i_dato_a  = a;
    bus.i_dato_b  = b;
    bus.i_op_code = op;
    bus.i_ready   = rdy;
    #1;
    o.valid = bus.o_valid;
    o.ready = bus.o_ready;
    o.res   = bus.o_resultado;
    o.flags = {bus.o_zero, bus.o_neg, bus.o_carry, bus.o_ovf, bus.o_op_err};
    cyc++;
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1;
    step(1'b0, 8'h00, 8'h00, 6'h00, 1'b1, o);
    step(1'b0, 8'h00, 8'h00, 6'h00, 1'b1, o);
    rst = 1'b0;
    step(1'b0, 8'h00, 8'h00, 6'h00, 1'b1, o);
    checks++;
    if (o.valid !== 1'b0 || o.ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_hs valid=%b ready=%b required valid=0 ready=1", o.valid, o.ready);
    end
    checks++;
    if (o.res !== 8'h00 || o.flags !== 5'b00000) begin
      failures++;
      $display("FAIL reset_out res=%h flags=%b required res=00 flags=00000", o.res, o.flags);
    end
  endtask

  task automatic test_directed();
    dvec_t tab [$];
    obs_t o;
`ifdef ALU_SATURATE_EN
    tab.push_back('{8'h7F, 8'h01, 6'b100000, 8'h7F, 5'b00010});
`else
    tab.push_back('{8'h7F, 8'h01, 6'b100000, 8'h80, 5'b01010});
`endif
    tab.push_back('{8'h00, 8'h01, 6'b100010, 8'hFF, 5'b01100});
    tab.push_back('{8'h05, 8'h05, 6'b100010, 8'h00, 5'b10000});
    tab.push_back('{8'h80, 8'h09, 6'b000011, 8'hFF, 5'b01000});
    tab.push_back('{8'h80, 8'h09, 6'b000010, 8'h00, 5'b10000});
    tab.push_back('{8'h80, 8'h02, 6'b000011, 8'hE0, 5'b01000});
    tab.push_back('{8'h80, 8'h02, 6'b000010, 8'h20, 5'b00000});
    tab.push_back('{8'h40, 8'h08, 6'b000011, 8'h00, 5'b10000});
    tab.push_back('{8'hFF, 8'h07, 6'b000010, 8'h01, 5'b00000});
    tab.push_back('{8'h3C, 8'h11, 6'b111111, 8'h3C, 5'b00001});
    tab.push_back('{8'hF0, 8'h3C, 6'b100100, 8'h30, 5'b00000});
    tab.push_back('{8'hF0, 8'h3C, 6'b100101, 8'hFC, 5'b01000});
    tab.push_back('{8'hF0, 8'h3C, 6'b100110, 8'hCC, 5'b01000});
    tab.push_back('{8'hF0, 8'h3C, 6'b100111, 8'h03, 5'b00000});
    tab.push_back('{8'hFF, 8'h01, 6'b100000, 8'h00, 5'b10100});
    foreach (tab[i]) begin
      step(1'b1, tab[i].a, tab[i].b, tab[i].op, 1'b1, o);
      step(1'b0, 8'h00, 8'h00, 6'h00, 1'b1, o);
      step(1'b0, 8'h00, 8'h00, 6'h00, 1'b1, o);
      checks++;
      if (o.valid !== 1'b1 || o.res !== tab[i].res || o.flags !== tab[i].flags) begin
        failures++;
        $display("FAIL directed[%0d] valid=%b res=%h flags=%b required valid=1 res=%h flags=%b",
                 i, o.valid, o.res, o.flags, tab[i].res, tab[i].flags);
      end
    end
    step(1'b0, 8'h00, 8'h00, 6'h00, 1'b1, o);
  endtask

  task automatic test_back_to_back();
    obs_t o;
    step(1'b1, 8'h10, 8'h20, 6'b100000, 1'b1, o);
    step(1'b1, 8'hF0, 8'h3C, 6'b100100, 1'b1, o);
    checks++;
    if (o.ready !== 1'b1 || o.valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first ready=%b valid=%b required ready=1 valid=0", o.ready, o.valid);
    end
    step(1'b0, 8'h00, 8'h00, 6'h00, 1'b1, o);
    checks++;
    if (o.valid !== 1'b1 || o.res !== 8'h30) begin
      failures++;
      $display("FAIL b2b_add valid=%b res=%h required valid=1 res=30", o.valid, o.res);
    end
    step(1'b0, 8'h00, 8'h00, 6'h00, 1'b1, o);
    checks++;
    if (o.valid !== 1'b1 || o.res !== 8'h30 || o.flags !== 5'b00000) begin
      failures++;
      $display("FAIL b2b_and valid=%b res=%h flags=%b required valid=1 res=30 flags=00000",
               o.valid, o.res, o.flags);
    end
    step(1'b0, 8'h00, 8'h00, 6'h00, 1'b1, o);
    checks++;
    if (o.valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end valid=%b required 0", o.valid);
    end
  endtask

  task automatic test_stall();
    obs_t o;
    logic [7:0] exp_res [8];
    logic       exp_vld [8];
    logic       exp_rdy [8];
    exp_vld = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_res = '{8'h00, 8'h00, 8'h03, 8'h03, 8'h03, 8'h05, 8'hA5, 8'h00};
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       step(1'b1, 8'h01, 8'h02, 6'b100000, 1'b0, o);
        1:       step(1'b1, 8'h09, 8'h04, 6'b100010, 1'b0, o);
        2, 3:    step(1'b1, 8'hAA, 8'h0F, 6'b100110, 1'b0, o);
        4:       step(1'b1, 8'hAA, 8'h0F, 6'b100110, 1'b1, o);
        default: step(1'b0, 8'h00, 8'h00, 6'h00, 1'b1, o);
      endcase
      checks++;
      if (o.valid !== exp_vld[i] || o.ready !== exp_rdy[i] || (exp_vld[i] && o.res !== exp_res[i])) begin
        failures++;
        $display("FAIL stall[%0d] valid=%b ready=%b res=%h required valid=%b ready=%b res=%h",
                 i, o.valid, o.ready, o.res, exp_vld[i], exp_rdy[i], exp_res[i]);
      end
    end
  endtask

  task automatic test_reset_flush();
    obs_t o;
    step(1'b1, 8'h11, 8'h22, 6'b100000, 1'b0, o);
    step(1'b1, 8'h33, 8'h44, 6'b100101, 1'b0, o);
    @(negedge clk);
    rst = 1'b1;
    bus.i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_resultado !== 8'h00 ||
        {bus.o_zero, bus.o_neg, bus.o_carry, bus.o_ovf, bus.o_op_err} !== 5'b00000) begin
      failures++;
      $display("FAIL flush_out valid=%b ready=%b res=%h required valid=0 ready=1 res=00 flags=0",
               bus.o_valid, bus.o_ready, bus.o_resultado);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 8'h00, 6'h00, 1'b1, o);
      checks++;
      if (o.valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_stale[%0d] valid=%b required 0", i, o.valid);
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic v, rdy, exp_rdy, exp_vld;
    logic [7:0] a, b;
    logic [5:0] op;
    logic [5:0] ops [9];
    ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
            6'b000011, 6'b000010, 6'b100111, 6'b000000};
    sb.delete();
    for (int i = 0; i < 420; i++) begin
      if (i < 400) begin
        v   = ($urandom_range(0, 9) < 7);
        rdy = ($urandom_range(0, 9) < 7);
      end else begin
        v   = 1'b0;
        rdy = 1'b1;
      end
      a  = 8'($urandom);
      op = ($urandom_range(0, 9) == 9) ? 6'($urandom) : ops[$urandom_range(0, 8)];
      b  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 11)) : 8'($urandom);
      step(v, a, b, op, rdy, o);
      exp_rdy = (sb.size() < 2) || rdy;
      exp_vld = (sb.size() > 0) && (sb[0].cyc <= cyc - 2);
      checks++;
      if (o.ready !== exp_rdy || o.valid !== exp_vld) begin
        failures++;
        $display("FAIL rand_hs[%0d] ready=%b valid=%b required ready=%b valid=%b",
                 i, o.ready, o.valid, exp_rdy, exp_vld);
      end
      if (o.valid === 1'b1 && sb.size() > 0) begin
        checks++;
        if (o.res !== sb[0].res || o.flags !== sb[0].flags) begin
          failures++;
          $display("FAIL rand_data[%0d] res=%h flags=%b required res=%h flags=%b",
                   i, o.res, o.flags, sb[0].res, sb[0].flags);
        end
        if (rdy) void'(sb.pop_front());
      end
      if (v && o.ready === 1'b1) begin
        e = model(a, b, op);
        e.cyc = cyc;
        sb.push_back(e);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL rand_drain pending=%0d required 0", sb.size());
    end
  endtask

  initial begin
    bus.i_valid   = 1'b0;
    bus.i_dato_a  = 8'h00;
    bus.i_dato_b  = 8'h00;
    bus.i_op_code = 6'h00;
    bus.i_ready   = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
